lossy_chan: RTL and testbench
=============================

# lossy_chan

Parametrised one-direction network channel for the TCP connection model, succeeding the fixed 4-bit `network` instance used in `dual_net`. It buffers up to DEPTH in-flight packets of DW bits and externalises every nondeterministic choice as an input, so a model checker or a random bench can resolve each one. The choices are loss on entry, whether a delivery happens this cycle, and which buffered packet is delivered. Two instances, forward for segments and reverse for ACKs, form a parametrised dual network between `tcp_snd` and `tcp_rcv`.

## Interface
- DW, 8: packet payload width. The TCP model packs {seq, len} or {seq, buff}.
- DEPTH, 4: buffer slots, 2..16.
- CW, $clog2(DEPTH+1): width of the occupancy count.
- PW, $clog2(DEPTH): width of the slot pick.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_val  in  1  packet offered this cycle
- in_data  in  DW  packet payload
- nd_drop  in  1  choice: lose the offered packet
- nd_deliver  in  1  choice: attempt a delivery this cycle
- nd_pick  in  PW  choice: slot index to deliver (used only with REORDER_EN)
- out_val  out  1  registered one-cycle delivery pulse
- out_data  out  DW  registered delivered payload; holds its last value when out_val=0
- count  out  CW  current occupancy
- full  out  1  count == DEPTH
- drops  out  8  saturating count of lost packets

## Operation
- Storage is an arrival-ordered compacting array: slot 0 is the oldest, and slots 0..count-1 are valid.
- Delivery is taken at an edge when nd_deliver=1 and count>0.
  - The delivered slot is k = nd_pick when REORDER_EN is defined and nd_pick < count; otherwise k = 0.
  - Slot k goes to out_data and out_val=1 for the following cycle.
  - Slots k+1..count-1 shift down by one.
- Acceptance is taken at an edge when in_val=1, nd_drop=0 and the post-delivery occupancy is < DEPTH.
  - The packet is written at the post-delivery tail index.
- Loss happens when in_val=1 and either nd_drop=1 or the post-delivery occupancy equals DEPTH. drops increments by 1 and saturates at 255.
- count_next = count − delivered + accepted.
- Simultaneous events:
  - On a full buffer, delivery frees the slot first, so an arrival in the same cycle is accepted and count stays DEPTH.
  - On an empty buffer, an arrival cannot be delivered in the same cycle.
- When nd_deliver=1 and count=0, out_val=0 and nothing changes.

## Timing
- Reset (rst_n=0 at an edge) sets out_val=0, out_data=0, count=0, full=0 and drops=0. All slot contents become don't-care.
- Reset takes priority over every other input. Asserting it mid-operation discards all in-flight packets without incrementing drops.
- Minimum latency is 2 edges: accepted at edge E, delivered at edge E+1 or later, visible on out_val in the cycle after E+1.
- Maximum latency is unbounded, because delivery is gated only by nd_deliver.
- There is no backpressure. in_val is never stalled, and overflow is treated as loss.
- count, full and drops are registered and reflect state after the last edge.

## Configuration
- REORDER_EN defined: nd_pick selects any valid slot, giving out-of-order delivery as the original network model does.
- REORDER_EN undefined: nd_pick is ignored and delivery is strictly oldest-first. The channel becomes a lossy FIFO.
- Loss and timing rules are identical in both builds.

## Structure
- Shared package `chan_pkg` holds:
  - the TCP field width SEQ_W=4;
  - the default DW = 2*SEQ_W;
  - DROP_W=8;
  - a `clog2`-style helper function for CW and PW.
- Sub-module `chan_slot_buf` holds the compacting storage array and takes these controls: remove-enable, remove-index, append-enable and append-data. `lossy_chan` keeps the choice decode, the output register and the counters.

## Test plan
All scenarios use DW=8 and DEPTH=4.
1. Reset, then in_val=1, in_data=8'h35, nd_drop=0 for 1 cycle → count=1. Then nd_deliver=1 → out_val=1 with out_data=8'h35 one cycle later, and count=0.
2. Send 8'h01..8'h05 back-to-back with nd_deliver=0 → count=4, full=1, drops=1, and 8'h05 is lost.
3. Full buffer holding 01..04, same cycle in_val=1 with 8'h0A and nd_deliver=1, nd_pick=0 → out_data=8'h01, count stays 4, buffer holds 02,03,04,0A, drops unchanged.
4. REORDER_EN, buffer holds 11,22,33; nd_deliver=1, nd_pick=2 → out 33, then pick=0 → 11, then pick=3 (≥ count) → 22.
5. REORDER_EN undefined, same buffer, nd_pick=2 → out 11 (oldest-first).
6. 300 packets with nd_drop=1 → drops saturates at 255. Then rst_n=0 for one edge mid-stream → count=0, drops=0, out_val=0.

Source files
------------

// File: rtl/chan_pkg.sv
// Shared constants and helpers for the lossy channel family (TCP model packs {seq, len}).
package chan_pkg;

  localparam int SEQ_W      = 4;
  localparam int DEFAULT_DW = 2 * SEQ_W;
  localparam int DROP_W     = 8;

  // Bits needed to encode values 0..value-1; used for count and slot-pick widths.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/lossy_chan_if.sv
// Channel bus: offered packet, nondeterministic choices, delivery pulse and status.
interface lossy_chan_if import chan_pkg::*; #(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = 4
) ();

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = clog2(DEPTH);

  logic              in_val;
  logic [DW-1:0]     in_data;
  logic              nd_drop;
  logic              nd_deliver;
  logic [PW-1:0]     nd_pick;
  logic              out_val;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     count;
  logic              full;
  logic [DROP_W-1:0] drops;

  modport master (
    output in_val, in_data, nd_drop, nd_deliver, nd_pick,
    input  out_val, out_data, count, full, drops
  );

  modport slave (
    input  in_val, in_data, nd_drop, nd_deliver, nd_pick,
    output out_val, out_data, count, full, drops
  );

endinterface

// File: rtl/chan_slot_buf.sv
// Arrival-ordered compacting storage: slot 0 is oldest, slots 0..count-1 valid.
module chan_slot_buf import chan_pkg::*; #(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = 4,
  parameter int CW    = clog2(DEPTH + 1),
  parameter int PW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [CW-1:0] count,
  input  logic          rem_en,
  input  logic [PW-1:0] rem_idx,
  output logic [DW-1:0] rem_data,
  input  logic          app_en,
  input  logic [DW-1:0] app_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] tail_idx;

  assign rem_data = mem[rem_idx];
  // Appends land after the removal has compacted the array.
  assign tail_idx = PW'(count - CW'(rem_en));

  // NOTE: storage has no reset; slots at or above count are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (rem_en && (PW'(i) >= rem_idx)) mem[i] <= mem[i+1];
    end
    // Last assignment wins when the tail slot is also a shift target.
    if (app_en) mem[tail_idx] <= app_data;
  end

endmodule

// File: rtl/lossy_chan.sv
// One-direction lossy channel with externalised loss/delivery/pick choices.
// Build option: define REORDER_EN to let nd_pick choose any valid slot (else oldest-first).
module lossy_chan import chan_pkg::*; #(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  lossy_chan_if.slave bus
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = clog2(DEPTH);

  logic          take;
  logic          accept;
  logic          lose;
  logic [PW-1:0] pick_idx;
  logic [CW-1:0] post_count;
  logic [CW-1:0] count_next;
  logic [DW-1:0] pick_data;

`ifndef REORDER_EN
  logic unused_pick;
  assign unused_pick = ^bus.nd_pick;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    take     = bus.nd_deliver && (bus.count != '0);
    pick_idx = '0;
`ifdef REORDER_EN
    if (CW'(bus.nd_pick) < bus.count) pick_idx = bus.nd_pick;
`endif
    post_count = bus.count - CW'(take);
    accept     = bus.in_val && !bus.nd_drop && (post_count < CW'(DEPTH));
    lose       = bus.in_val && !accept;
    count_next = post_count + CW'(accept);
  end

  chan_slot_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW),
    .PW    (PW)
  ) u_slot_buf (
    .clk      (clk),
    .count    (bus.count),
    .rem_en   (take),
    .rem_idx  (pick_idx),
    .rem_data (pick_data),
    .app_en   (accept),
    .app_data (bus.in_data)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_val  <= 1'b0;
      bus.out_data <= '0;
      bus.count    <= '0;
      bus.full     <= 1'b0;
      bus.drops    <= '0;
    end else begin
      bus.out_val <= take;
      if (take) bus.out_data <= pick_data;
      bus.count <= count_next;
      bus.full  <= (count_next == CW'(DEPTH));
      if (lose && (bus.drops != '1)) bus.drops <= bus.drops + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_lossy_chan.sv
// Self-checking bench for lossy_chan: queue-based reference model plus directed literal checks.
module tb_lossy_chan;
  import chan_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lossy_chan_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  lossy_chan #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: a queue of in-flight packets, oldest at the front.
  logic [DW-1:0] q[$];
  logic          exp_val  = 1'b0;
  logic [DW-1:0] exp_data = '0;
  int            exp_drops = 0;
  bit            model_on  = 1'b0;

  always @(posedge clk) begin
    int k;
    if (!rst_n) begin
      q.delete();
      exp_val   = 1'b0;
      exp_data  = '0;
      exp_drops = 0;
      model_on  = 1'b1;
    end else if (model_on) begin
      exp_val = 1'b0;
      if (bus.nd_deliver && q.size() > 0) begin
        k = 0;
`ifdef REORDER_EN
        if (int'(bus.nd_pick) < q.size()) k = int'(bus.nd_pick);
`endif
        exp_data = q[k];
        q.delete(k);
        exp_val = 1'b1;
      end
      if (bus.in_val) begin
        if (!bus.nd_drop && q.size() < DEPTH) q.push_back(bus.in_data);
        else if (exp_drops < 255) exp_drops++;
      end
    end
    #1;
    if (model_on) begin
      check("m_out_val",  bus.out_val,  exp_val);
      check("m_out_data", bus.out_data, exp_data);
      check("m_count",    bus.count,    q.size());
      check("m_full",     bus.full,     q.size() == DEPTH);
      check("m_drops",    bus.drops,    exp_drops);
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic drop,
                     input logic del, input logic [1:0] pick);
    bus.in_val     = v;
    bus.in_data    = d;
    bus.nd_drop    = drop;
    bus.nd_deliver = del;
    bus.nd_pick    = pick;
    @(negedge clk);
  endtask

  initial begin
    bus.in_val = 1'b0; bus.in_data = '0; bus.nd_drop = 1'b0;
    bus.nd_deliver = 1'b0; bus.nd_pick = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_count", bus.count, 0);
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_full", bus.full, 0);
    check("rst_drops", bus.drops, 0);

    // Single packet through.
    cyc(1, 8'h35, 0, 0, 0);
    check("s1_count_after_accept", bus.count, 1);
    cyc(0, 8'h00, 0, 1, 0);
    check("s1_out_val", bus.out_val, 1);
    check("s1_out_data", bus.out_data, 8'h35);
    check("s1_count_after_deliver", bus.count, 0);
    cyc(0, 8'h00, 0, 1, 0);
    check("s1_empty_deliver_val", bus.out_val, 0);
    check("s1_out_data_held", bus.out_data, 8'h35);

    // Overflow loses the fifth packet.
    for (int i = 1; i <= 5; i++) cyc(1, DW'(i), 0, 0, 0);
    check("s2_count", bus.count, 4);
    check("s2_full", bus.full, 1);
    check("s2_drops", bus.drops, 1);

    // Full buffer: delivery frees a slot for the simultaneous arrival.
    cyc(1, 8'h0A, 0, 1, 0);
    check("s3_out_data", bus.out_data, 8'h01);
    check("s3_count", bus.count, 4);
    check("s3_drops", bus.drops, 1);
    cyc(0, 8'h00, 0, 1, 0); check("s3_drain0", bus.out_data, 8'h02);
    cyc(0, 8'h00, 0, 1, 0); check("s3_drain1", bus.out_data, 8'h03);
    cyc(0, 8'h00, 0, 1, 0); check("s3_drain2", bus.out_data, 8'h04);
    cyc(0, 8'h00, 0, 1, 0); check("s3_drain3", bus.out_data, 8'h0A);
    check("s3_empty", bus.count, 0);

    // Pick handling.
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    cyc(1, 8'h33, 0, 0, 0);
`ifdef REORDER_EN
    cyc(0, 8'h00, 0, 1, 2); check("s4_pick2", bus.out_data, 8'h33);
    cyc(0, 8'h00, 0, 1, 0); check("s4_pick0", bus.out_data, 8'h11);
    cyc(0, 8'h00, 0, 1, 3); check("s4_pick_oob", bus.out_data, 8'h22);
`else
    cyc(0, 8'h00, 0, 1, 2); check("s5_fifo0", bus.out_data, 8'h11);
    cyc(0, 8'h00, 0, 1, 2); check("s5_fifo1", bus.out_data, 8'h22);
    cyc(0, 8'h00, 0, 1, 2); check("s5_fifo2", bus.out_data, 8'h33);
`endif
    check("s45_empty", bus.count, 0);

    // Drop counter saturation, then reset mid-stream.
    cyc(1, 8'h77, 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, DW'(i), 1, 0, 0);
    check("s6_drops_sat", bus.drops, 255);
    check("s6_count", bus.count, 1);
    rst_n = 1'b0;
    cyc(1, 8'h88, 1, 1, 0);
    rst_n = 1'b1;
    check("s6_rst_count", bus.count, 0);
    check("s6_rst_drops", bus.drops, 0);
    check("s6_rst_out_val", bus.out_val, 0);
    check("s6_rst_full", bus.full, 0);

    // Randomised traffic under varying delivery pressure.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1000; i++) begin
        rst_n = ($urandom_range(0, 299) != 0);
        cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) < p + 1, 2'($urandom_range(0, 3)));
      end
    end
    rst_n = 1'b1;
    cyc(0, 8'h00, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
